// File: rtl/multdiv_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : multdiv_ctrl_if
// Brief    : Pipeline request/response and mult/div unit signals of multdiv_ctrl
// Revision : 1.0 - initial release
// ============================================================================
interface multdiv_ctrl_if;
    logic        req_valid;
    logic        req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [4:0]  req_dest;
    logic        req_ready;
    logic        flush;

    logic [31:0] unit_a;
    logic [31:0] unit_b;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] mult_result;
    logic [31:0] div_result;
    logic        mult_exc;
    logic        div_exc;
    logic        mult_rdy;
    logic        div_rdy;

    logic        resp_valid;
    logic [31:0] resp_result;
    logic        resp_exception;
    logic        resp_timeout;
    logic [4:0]  resp_dest;
    logic        resp_ack;
    logic        busy;

    // Controller side
    modport slave (
        input  req_valid, req_op, req_a, req_b, req_dest, flush,
        input  mult_result, div_result, mult_exc, div_exc, mult_rdy, div_rdy,
        input  resp_ack,
        output req_ready, unit_a, unit_b, ctrl_MULT, ctrl_DIV,
        output resp_valid, resp_result, resp_exception, resp_timeout, resp_dest,
        output busy
    );

    // Pipeline plus unit side
    modport master (
        output req_valid, req_op, req_a, req_b, req_dest, flush,
        output mult_result, div_result, mult_exc, div_exc, mult_rdy, div_rdy,
        output resp_ack,
        input  req_ready, unit_a, unit_b, ctrl_MULT, ctrl_DIV,
        input  resp_valid, resp_result, resp_exception, resp_timeout, resp_dest,
        input  busy
    );
endinterface
`default_nettype wire

// File: rtl/multdiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multdiv_ctrl
// Brief    : One-at-a-time sequencer for the iterative multiply/divide units
// Revision : 1.0 - initial release
// ============================================================================
module multdiv_ctrl #(
    parameter int TIMEOUT = 40
) (
    input  logic           clk,
    input  logic           nrst,
    multdiv_ctrl_if.slave  bus
);
    localparam int c_CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [31:0]        r_a;
    logic [31:0]        r_b;
    logic               r_op;
    logic [4:0]         r_dest;
    logic [c_CNT_W-1:0] r_cnt;
    logic [31:0]        r_res;
    logic               r_exc;
    logic               r_tmo;

    logic w_req_ready;
    logic w_accept;
    logic w_div0;
    logic w_sel_rdy;
    logic w_rdy_hit;
    logic w_tmo_hit;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_req_ready  = (r_state == S_IDLE) && !bus.flush;
        w_accept     = bus.req_valid && w_req_ready;
        w_div0       = bus.req_op && (bus.req_b == 32'd0);
        w_sel_rdy    = r_op ? bus.div_rdy : bus.mult_rdy;
        // Counter 0 blanks the rdy level left over from the previous operation
        w_rdy_hit    = (r_state == S_WAIT) && (r_cnt != '0) && w_sel_rdy;
        w_tmo_hit    = (r_state == S_WAIT) && (r_cnt == c_CNT_LAST) && !w_rdy_hit;

        case (r_state)
            S_IDLE:   if (w_accept) w_state_next = w_div0 ? S_RESP : S_LAUNCH;
            S_LAUNCH: w_state_next = S_WAIT;
            S_WAIT:   if (w_rdy_hit || w_tmo_hit) w_state_next = S_RESP;
            S_RESP:   if (bus.resp_ack) w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
        if (bus.flush) begin
            w_state_next = S_IDLE;
        end

        bus.req_ready      = w_req_ready;
        bus.ctrl_MULT      = (r_state == S_LAUNCH) && !r_op;
        bus.ctrl_DIV       = (r_state == S_LAUNCH) && r_op;
        bus.resp_valid     = (r_state == S_RESP);
        bus.busy           = (r_state != S_IDLE);
        bus.unit_a         = r_a;
        bus.unit_b         = r_b;
        bus.resp_result    = r_res;
        bus.resp_exception = r_exc;
        bus.resp_timeout   = r_tmo;
        bus.resp_dest      = r_dest;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_op   <= 1'b0;
            r_dest <= '0;
            r_cnt  <= '0;
            r_res  <= '0;
            r_exc  <= 1'b0;
            r_tmo  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a    <= bus.req_a;
                r_b    <= bus.req_b;
                r_op   <= bus.req_op;
                r_dest <= bus.req_dest;
                if (w_div0) begin
                    r_res <= '0;
                    r_exc <= 1'b1;
                    r_tmo <= 1'b0;
                end
            end

            if (r_state == S_LAUNCH) begin
                r_cnt <= '0;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (!bus.flush) begin
                if (w_rdy_hit) begin
                    r_res <= r_op ? bus.div_result : bus.mult_result;
                    r_exc <= r_op ? bus.div_exc : bus.mult_exc;
                    r_tmo <= 1'b0;
                end else if (w_tmo_hit) begin
                    r_res <= '0;
                    r_exc <= 1'b1;
                    r_tmo <= 1'b1;
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_multdiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_multdiv_ctrl
// Brief    : Table-driven, scoreboarded bench for multdiv_ctrl with a unit model
// Revision : 1.0 - initial release
// ============================================================================
module tb_multdiv_ctrl;
    localparam int TIMEOUT = 40;

    logic clk = 1'b0;
    logic nrst;
    always #5 clk = ~clk;

    multdiv_ctrl_if bus();

    multdiv_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    typedef struct {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  dest;
        int          delay;   // unit rdy this many cycles after the pulse, 0 = never
        logic [31:0] u_res;
        logic        u_exc;
        bit          stale;   // unit keeps its old rdy level for one extra cycle
        logic [31:0] e_res;
        logic        e_exc;
        logic        e_tmo;
        int          e_n;     // negedges after the accept edge until resp_valid is seen
        int          e_mp;
        int          e_dp;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        logic        tmo;
        logic [4:0]  dest;
        logic [31:0] a;
        logic [31:0] b;
        int          n;
    } exp_t;

    exp_t        sb[$];
    vec_t        tbl[7];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cfg_delay = 3;
    bit          cfg_stale = 1'b0;
    logic [31:0] cfg_res = 32'd0;
    logic        cfg_exc = 1'b0;
    int          mult_pulses = 0;
    int          div_pulses  = 0;

    // Behavioural mult/div unit: level rdy that drops when a new op starts
    initial begin
        int cnt;
        bit is_div;
        bit active;
        cnt = 0; is_div = 1'b0; active = 1'b0;
        bus.mult_rdy = 1'b0; bus.div_rdy = 1'b0;
        bus.mult_result = 32'd0; bus.div_result = 32'd0;
        bus.mult_exc = 1'b0; bus.div_exc = 1'b0;
        forever begin
            @(negedge clk);
            if (!nrst) begin
                bus.mult_rdy = 1'b0; bus.div_rdy = 1'b0;
                active = 1'b0; cnt = 0;
            end else if (bus.ctrl_MULT || bus.ctrl_DIV) begin
                if (bus.ctrl_MULT) mult_pulses++;
                if (bus.ctrl_DIV) div_pulses++;
                is_div = bus.ctrl_DIV;
                active = 1'b1;
                cnt = 0;
                if (!cfg_stale) begin
                    if (is_div) bus.div_rdy = 1'b0; else bus.mult_rdy = 1'b0;
                end
            end else if (active) begin
                cnt++;
                if (cnt == 2) begin
                    if (is_div) bus.div_rdy = 1'b0; else bus.mult_rdy = 1'b0;
                end
                if (cnt == cfg_delay) begin
                    if (is_div) begin
                        bus.div_result = cfg_res; bus.div_exc = cfg_exc; bus.div_rdy = 1'b1;
                    end else begin
                        bus.mult_result = cfg_res; bus.mult_exc = cfg_exc; bus.mult_rdy = 1'b1;
                    end
                    active = 1'b0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic vec_t mk(input logic op, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] dest, input int delay, input logic [31:0] u_res,
                                input logic u_exc, input bit stale, input logic [31:0] e_res,
                                input logic e_exc, input logic e_tmo, input int e_n,
                                input int e_mp, input int e_dp);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.dest = dest; v.delay = delay;
        v.u_res = u_res; v.u_exc = u_exc; v.stale = stale;
        v.e_res = e_res; v.e_exc = e_exc; v.e_tmo = e_tmo; v.e_n = e_n;
        v.e_mp = e_mp; v.e_dp = e_dp;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge following the accept edge
    task automatic send(input vec_t v, input bit push, input string nm);
        int k;
        exp_t e;
        cfg_delay = v.delay; cfg_stale = v.stale; cfg_res = v.u_res; cfg_exc = v.u_exc;
        bus.req_valid = 1'b1; bus.req_op = v.op;
        bus.req_a = v.a; bus.req_b = v.b; bus.req_dest = v.dest;
        if (push) begin
            e.res = v.e_res; e.exc = v.e_exc; e.tmo = v.e_tmo; e.dest = v.dest;
            e.a = v.a; e.b = v.b; e.n = v.e_n;
            sb.push_back(e);
        end
        k = 0;
        #1;
        while (!bus.req_ready && k < 50) begin
            @(negedge clk); #1; k++;
        end
        chk({nm, "_req_ready"}, {31'd0, bus.req_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic collect(input string nm);
        int n;
        exp_t e;
        n = 1;
        while (!bus.resp_valid && n < 100) begin
            @(negedge clk); n++;
        end
        chk({nm, "_resp_valid"}, {31'd0, bus.resp_valid}, 32'd1);
        chk({nm, "_sb_nonempty"}, {31'd0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({nm, "_latency"}, n, e.n);
            chk({nm, "_result"}, bus.resp_result, e.res);
            chk({nm, "_exception"}, {31'd0, bus.resp_exception}, {31'd0, e.exc});
            chk({nm, "_timeout"}, {31'd0, bus.resp_timeout}, {31'd0, e.tmo});
            chk({nm, "_dest"}, {27'd0, bus.resp_dest}, {27'd0, e.dest});
            chk({nm, "_unit_a"}, bus.unit_a, e.a);
            chk({nm, "_unit_b"}, bus.unit_b, e.b);
            @(negedge clk);
            @(negedge clk);
            chk({nm, "_hold_valid"}, {31'd0, bus.resp_valid}, 32'd1);
            chk({nm, "_hold_result"}, bus.resp_result, e.res);
        end
        bus.resp_ack = 1'b1;
        @(negedge clk);
        bus.resp_ack = 1'b0;
        #1;
        chk({nm, "_post_ack_valid"}, {31'd0, bus.resp_valid}, 32'd0);
        chk({nm, "_post_ack_busy"}, {31'd0, bus.busy}, 32'd0);
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int mp0;
        int dp0;
        mp0 = mult_pulses;
        dp0 = div_pulses;
        send(v, 1'b1, nm);
        collect(nm);
        chk({nm, "_mult_pulses"}, mult_pulses - mp0, v.e_mp);
        chk({nm, "_div_pulses"}, div_pulses - dp0, v.e_dp);
    endtask

    task automatic flush_seq();
        vec_t v_old;
        vec_t v_new;
        int   mp0;
        v_old = mk(1'b0, 32'd9, 32'd9, 5'd7, 20, 32'd81, 1'b0, 1'b0, 32'd81, 1'b0, 1'b0, 0, 1, 0);
        v_new = mk(1'b0, 32'd3, 32'd4, 5'd21, 3, 32'd12, 1'b0, 1'b0, 32'd12, 1'b0, 1'b0, 5, 1, 0);
        send(v_old, 1'b0, "fl_old");
        @(negedge clk);
        @(negedge clk);
        bus.resp_ack = 1'b1;
        @(negedge clk);
        bus.resp_ack = 1'b0;
        #1;
        chk("fl_ack_ignored_busy", {31'd0, bus.busy}, 32'd1);
        chk("fl_ack_ignored_valid", {31'd0, bus.resp_valid}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        // WAIT counter 5: flush with a new request already presented
        bus.flush = 1'b1;
        bus.req_valid = 1'b1; bus.req_op = 1'b0;
        bus.req_a = 32'd3; bus.req_b = 32'd4; bus.req_dest = 5'd21;
        @(negedge clk);
        chk("fl_idle_busy", {31'd0, bus.busy}, 32'd0);
        chk("fl_no_resp", {31'd0, bus.resp_valid}, 32'd0);
        chk("fl_ready_low", {31'd0, bus.req_ready}, 32'd0);
        @(negedge clk);
        chk("fl_not_accepted", {31'd0, bus.busy}, 32'd0);
        chk("fl_ready_still_low", {31'd0, bus.req_ready}, 32'd0);
        bus.flush = 1'b0;
        mp0 = mult_pulses;
        send(v_new, 1'b1, "fl_new");
        collect("fl_new");
        chk("fl_new_mult_pulses", mult_pulses - mp0, 1);
    endtask

    task automatic reset_seq();
        vec_t v;
        v = mk(1'b0, 32'hAAAA5555, 32'h12345678, 5'd12, 5, 32'd1, 1'b0, 1'b0, 32'd1, 1'b0, 1'b0, 0, 1, 0);
        send(v, 1'b0, "rr");
        #1;
        chk("rr_pulse_seen", {31'd0, bus.ctrl_MULT}, 32'd1);
        nrst = 1'b0;
        #1;
        chk("rr_mult_drop", {31'd0, bus.ctrl_MULT}, 32'd0);
        chk("rr_div_low", {31'd0, bus.ctrl_DIV}, 32'd0);
        chk("rr_busy", {31'd0, bus.busy}, 32'd0);
        chk("rr_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("rr_unit_a", bus.unit_a, 32'd0);
        chk("rr_unit_b", bus.unit_b, 32'd0);
        chk("rr_resp_dest", {27'd0, bus.resp_dest}, 32'd0);
        chk("rr_resp_result", bus.resp_result, 32'd0);
        chk("rr_req_ready", {31'd0, bus.req_ready}, 32'd1);
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        #1;
        chk("rr_after_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rr_after_busy", {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        nrst = 1'b0;
        bus.req_valid = 1'b0; bus.req_op = 1'b0;
        bus.req_a = 32'd0; bus.req_b = 32'd0; bus.req_dest = 5'd0;
        bus.flush = 1'b0; bus.resp_ack = 1'b0;

        //          op    a             b             dest  dly u_res         u_exc stale e_res        e_exc e_tmo n   mp dp
        tbl[0] = mk(1'b0, 32'd7,        32'hFFFFFFFA, 5'd5,  33, 32'hFFFFFFD6, 1'b0, 1'b0, 32'hFFFFFFD6, 1'b0, 1'b0, 35, 1, 0);
        tbl[1] = mk(1'b1, 32'd100,      32'd0,        5'd9,  3,  32'h00000BAD, 1'b0, 1'b0, 32'd0,        1'b1, 1'b0, 1,  0, 0);
        tbl[2] = mk(1'b1, 32'd50,       32'd5,        5'd3,  3,  32'd10,       1'b0, 1'b0, 32'd10,       1'b0, 1'b0, 5,  0, 1);
        tbl[3] = mk(1'b1, 32'd100,      32'd7,        5'd17, 5,  32'd14,       1'b0, 1'b1, 32'd14,       1'b0, 1'b0, 7,  0, 1);
        tbl[4] = mk(1'b0, 32'h1234,     32'h5678,     5'd30, 0,  32'd0,        1'b0, 1'b0, 32'd0,        1'b1, 1'b1, 42, 1, 0);
        tbl[5] = mk(1'b0, 32'hFFFF,     32'd2,        5'd1,  2,  32'h1FFFE,    1'b1, 1'b0, 32'h1FFFE,    1'b1, 1'b0, 4,  1, 0);
        tbl[6] = mk(1'b1, 32'hFFFFFFEC, 32'd3,        5'd31, 10, 32'hFFFFFFFA, 1'b0, 1'b0, 32'hFFFFFFFA, 1'b0, 1'b0, 12, 0, 1);

        #12;
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("rst_ctrl_mult", {31'd0, bus.ctrl_MULT}, 32'd0);
        chk("rst_ctrl_div", {31'd0, bus.ctrl_DIV}, 32'd0);
        chk("rst_resp_exc", {31'd0, bus.resp_exception}, 32'd0);
        chk("rst_resp_tmo", {31'd0, bus.resp_timeout}, 32'd0);
        chk("rst_resp_result", bus.resp_result, 32'd0);
        chk("rst_unit_a", bus.unit_a, 32'd0);
        @(negedge clk);
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);

        foreach (tbl[i]) begin
            run_vec(tbl[i], $sformatf("v%0d", i));
        end
        flush_seq();
        reset_seq();
        run_vec(tbl[5], "post_rst");
        chk("sb_drained", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
